// File: rtl/jtvigil_vtimer_prog_if.sv
// rtl/jtvigil_vtimer_prog_if.sv - configuration register bus for the programmable raster timer
interface jtvigil_vtimer_prog_if #(
    parameter int DW = 9
);
    logic          cfg_we;
    logic [3:0]    cfg_addr;
    logic [DW-1:0] cfg_din;
    logic [DW-1:0] cfg_dout;

    modport master (output cfg_we, output cfg_addr, output cfg_din, input cfg_dout);
    modport slave  (input cfg_we, input cfg_addr, input cfg_din, output cfg_dout);
endinterface

// File: rtl/jtvigil_vtimer_prog.sv
// rtl/jtvigil_vtimer_prog.sv - raster timing generator with frame-end committed timing registers
module jtvigil_vtimer_prog #(
    parameter int HW       = 9,
    parameter int VW       = 9,
    parameter int HB_END   = 9,
    parameter int HB_START = 265,
    parameter int HS_START = 305,
    parameter int HS_END   = 337,
    parameter int HCNT_END = 383,
    parameter int VB_START = 256,
    parameter int VS_START = 264,
    parameter int VS_END   = 270,
    parameter int VCNT_END = 283
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pxl_cen,
    jtvigil_vtimer_prog_if.slave       cfg,
    output logic [HW-1:0]              h,
    output logic [VW-1:0]              v,
    output logic [VW-1:0]              vrender,
    output logic                       LHBL,
    output logic                       LVBL,
    output logic                       HS,
    output logic                       VS,
    output logic                       hinit,
    output logic                       vinit,
    output logic                       line_irq,
    output logic                       field
);
    localparam int DW = (HW > VW) ? HW : VW;

    // Index order: HB_END, HB_START, HS_START, HS_END, HCNT_END / VB_START, VS_START, VS_END, VCNT_END
    localparam logic [HW-1:0] H_DEF [5] = '{HW'(HB_END), HW'(HB_START), HW'(HS_START),
                                            HW'(HS_END), HW'(HCNT_END)};
    localparam logic [VW-1:0] V_DEF [4] = '{VW'(VB_START), VW'(VS_START), VW'(VS_END),
                                            VW'(VCNT_END)};

    logic [HW-1:0] sh_h_q [5];
    logic [HW-1:0] sh_h_d [5];
    logic [HW-1:0] ac_h_q [5];
    logic [HW-1:0] ac_h_d [5];
    logic [VW-1:0] sh_v_q [4];
    logic [VW-1:0] sh_v_d [4];
    logic [VW-1:0] ac_v_q [4];
    logic [VW-1:0] ac_v_d [4];
    logic [VW-1:0] irq_line_q, irq_line_d;
    logic          irq_en_q, irq_en_d;
    logic [DW-1:0] cfg_dout_q, cfg_dout_d;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d, vrender_q, vrender_d;
    logic          lhbl_q, lhbl_d, lvbl_q, lvbl_d, hs_q, hs_d, vs_q, vs_d;
    logic          hinit_q, vinit_q, irq_q, field_q;
    logic          h_wrap, v_wrap, commit;

    always_comb begin
        sh_h_d     = sh_h_q;
        sh_v_d     = sh_v_q;
        irq_line_d = irq_line_q;
        irq_en_d   = irq_en_q;
        if (cfg.cfg_we) begin
            case (cfg.cfg_addr)
                4'd0:    sh_h_d[0]  = cfg.cfg_din[HW-1:0];
                4'd1:    sh_h_d[1]  = cfg.cfg_din[HW-1:0];
                4'd2:    sh_h_d[2]  = cfg.cfg_din[HW-1:0];
                4'd3:    sh_h_d[3]  = cfg.cfg_din[HW-1:0];
                4'd4:    sh_h_d[4]  = cfg.cfg_din[HW-1:0];
                4'd5:    sh_v_d[0]  = cfg.cfg_din[VW-1:0];
                4'd6:    sh_v_d[1]  = cfg.cfg_din[VW-1:0];
                4'd7:    sh_v_d[2]  = cfg.cfg_din[VW-1:0];
                4'd8:    sh_v_d[3]  = cfg.cfg_din[VW-1:0];
                4'd9:    irq_line_d = cfg.cfg_din[VW-1:0];
                4'd10:   irq_en_d   = cfg.cfg_din[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        cfg_dout_d = '0;
        case (cfg.cfg_addr)
            4'd0:    cfg_dout_d = DW'(sh_h_q[0]);
            4'd1:    cfg_dout_d = DW'(sh_h_q[1]);
            4'd2:    cfg_dout_d = DW'(sh_h_q[2]);
            4'd3:    cfg_dout_d = DW'(sh_h_q[3]);
            4'd4:    cfg_dout_d = DW'(sh_h_q[4]);
            4'd5:    cfg_dout_d = DW'(sh_v_q[0]);
            4'd6:    cfg_dout_d = DW'(sh_v_q[1]);
            4'd7:    cfg_dout_d = DW'(sh_v_q[2]);
            4'd8:    cfg_dout_d = DW'(sh_v_q[3]);
            4'd9:    cfg_dout_d = DW'(irq_line_q);
            4'd10:   cfg_dout_d = DW'(irq_en_q);
            default: cfg_dout_d = '0;
        endcase
    end

    // Strobes compare against the set that will be active after this edge, so the
    // first line of a frame already reflects a freshly committed configuration.
    always_comb begin
        h_wrap = (h_q == ac_h_q[4]);
        v_wrap = (v_q == ac_v_q[3]);
        commit = pxl_cen && h_wrap && v_wrap;
        ac_h_d = commit ? sh_h_q : ac_h_q;
        ac_v_d = commit ? sh_v_q : ac_v_q;
        h_d    = h_wrap ? '0 : h_q + HW'(1);
        v_d    = h_wrap ? (v_wrap ? '0 : v_q + VW'(1)) : v_q;
        vrender_d = (v_d == ac_v_d[3]) ? '0 : v_d + VW'(1);
        lhbl_d = (h_d >= ac_h_d[0]) && (h_d < ac_h_d[1]);
        hs_d   = (h_d >= ac_h_d[2]) && (h_d < ac_h_d[3]);
        lvbl_d = (v_d < ac_v_d[0]);
        vs_d   = (v_d >= ac_v_d[1]) && (v_d < ac_v_d[2]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                sh_h_q[i] <= H_DEF[i];
                ac_h_q[i] <= H_DEF[i];
            end
            for (int i = 0; i < 4; i++) begin
                sh_v_q[i] <= V_DEF[i];
                ac_v_q[i] <= V_DEF[i];
            end
            irq_line_q <= '0;
            irq_en_q   <= 1'b0;
            cfg_dout_q <= '0;
            h_q        <= '0;
            v_q        <= '0;
            vrender_q  <= VW'(1);
            lhbl_q     <= 1'b0;
            lvbl_q     <= 1'b1;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            hinit_q    <= 1'b0;
            vinit_q    <= 1'b0;
            irq_q      <= 1'b0;
            field_q    <= 1'b0;
        end else begin
            sh_h_q     <= sh_h_d;
            sh_v_q     <= sh_v_d;
            ac_h_q     <= ac_h_d;
            ac_v_q     <= ac_v_d;
            irq_line_q <= irq_line_d;
            irq_en_q   <= irq_en_d;
            cfg_dout_q <= cfg_dout_d;
            hinit_q    <= 1'b0;
            vinit_q    <= 1'b0;
            irq_q      <= 1'b0;
            if (pxl_cen) begin
                h_q       <= h_d;
                v_q       <= v_d;
                vrender_q <= vrender_d;
                lhbl_q    <= lhbl_d;
                lvbl_q    <= lvbl_d;
                hs_q      <= hs_d;
                vs_q      <= vs_d;
                hinit_q   <= h_wrap;
                vinit_q   <= h_wrap && v_wrap;
                irq_q     <= h_wrap && irq_en_q && (v_d == irq_line_q);
                if (h_wrap && v_wrap) field_q <= ~field_q;
            end
        end
    end

    assign cfg.cfg_dout = cfg_dout_q;
    assign h        = h_q;
    assign v        = v_q;
    assign vrender  = vrender_q;
    assign LHBL     = lhbl_q;
    assign LVBL     = lvbl_q;
    assign HS       = hs_q;
    assign VS       = vs_q;
    assign hinit    = hinit_q;
    assign vinit    = vinit_q;
    assign line_irq = irq_q;
    assign field    = field_q;
endmodule

// File: tb/tb_jtvigil_vtimer_prog.sv
// tb/tb_jtvigil_vtimer_prog.sv - directed vector bench for jtvigil_vtimer_prog
module tb_jtvigil_vtimer_prog;
    logic       clk = 1'b0;
    logic       rst;
    logic       pxl_cen;
    logic [8:0] h, v, vrender;
    logic       LHBL, LVBL, HS, VS, hinit, vinit, line_irq, field;

    jtvigil_vtimer_prog_if #(.DW(9)) cfg_if ();

    // Short lines keep whole frames cheap; the vertical timing stays at its defaults.
    jtvigil_vtimer_prog #(
        .HB_END(2), .HB_START(20), .HS_START(24), .HS_END(28), .HCNT_END(31)
    ) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .cfg(cfg_if),
        .h(h), .v(v), .vrender(vrender),
        .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS),
        .hinit(hinit), .vinit(vinit), .line_irq(line_irq), .field(field)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [3:0] addr; logic [8:0] din; logic [8:0] exp; } reg_vec_t;
    typedef struct { int pos; logic lvl_blank; logic lvl_sync; } pos_vec_t;

    int n_chk = 0;
    int n_fail = 0;
    int gap = 0;
    int f_cens, f_maxh, f_hinit, f_irq, f_irq_v, f_irq_h, f_hb_fall, f_lvbl_low, f_vs_hi;
    logic lvbl_v [512];
    logic vs_v   [512];
    logic lhbl_h [512];
    logic hs_h   [512];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic pix();
        for (int i = 0; i < gap; i++) begin
            pxl_cen = 1'b0;
            clk1();
        end
        pxl_cen = 1'b1;
        clk1();
        pxl_cen = 1'b0;
    endtask

    task automatic cfg_wr(input logic [3:0] a, input logic [8:0] d);
        cfg_if.cfg_we   = 1'b1;
        cfg_if.cfg_addr = a;
        cfg_if.cfg_din  = d;
        clk1();
        cfg_if.cfg_we   = 1'b0;
    endtask

    task automatic cfg_rd(input logic [3:0] a, output logic [8:0] d);
        cfg_if.cfg_addr = a;
        clk1();
        d = cfg_if.cfg_dout;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clk1();
        rst = 1'b0;
    endtask

    // Runs until the next vinit, optionally writing a register at the start of line act_v
    // and another register on the frame-wrap (commit) edge itself.
    task automatic run_frame(input int hend, input int act_v, input logic [3:0] act_a,
                             input logic [8:0] act_d, input logic ce_en,
                             input logic [3:0] ce_a, input logic [8:0] ce_d);
        logic acted, done, prev_lhbl;
        f_cens = 0; f_maxh = 0; f_hinit = 0; f_irq = 0; f_irq_v = -1; f_irq_h = -1;
        f_hb_fall = -1; f_lvbl_low = 0; f_vs_hi = 0;
        acted = 1'b0; done = 1'b0; prev_lhbl = LHBL;
        while (!done && f_cens < 20000) begin
            if (act_v >= 0 && !acted && v == 9'(act_v) && h == 9'd0) begin
                cfg_wr(act_a, act_d);
                acted = 1'b1;
            end
            if (ce_en && h == 9'(hend) && v == 9'd283) begin
                cfg_if.cfg_we   = 1'b1;
                cfg_if.cfg_addr = ce_a;
                cfg_if.cfg_din  = ce_d;
            end
            pix();
            cfg_if.cfg_we = 1'b0;
            f_cens++;
            if (int'(h) > f_maxh) f_maxh = int'(h);
            if (hinit) f_hinit++;
            if (line_irq) begin
                f_irq++;
                f_irq_v = int'(v);
                f_irq_h = int'(h);
            end
            if (prev_lhbl && !LHBL && f_hb_fall < 0) f_hb_fall = int'(h);
            prev_lhbl = LHBL;
            if (h == 9'd0) begin
                lvbl_v[v] = LVBL;
                vs_v[v]   = VS;
                if (!LVBL) f_lvbl_low++;
                if (VS) f_vs_hi++;
            end
            if (vinit) done = 1'b1;
        end
        chk("frame_end_reached", 32'(done), 32'd1);
    endtask

    initial begin
        reg_vec_t   rv [11];
        pos_vec_t   hv [10];
        pos_vec_t   vv [8];
        logic [8:0] rd;
        int         hs_cnt, lb_cnt, hs_first, n;

        rv[0]  = '{1'b0, 4'd0,  9'd0,   9'd2};
        rv[1]  = '{1'b0, 4'd4,  9'd0,   9'd31};
        rv[2]  = '{1'b0, 4'd5,  9'd0,   9'd256};
        rv[3]  = '{1'b0, 4'd8,  9'd0,   9'd283};
        rv[4]  = '{1'b0, 4'd9,  9'd0,   9'd0};
        rv[5]  = '{1'b1, 4'd9,  9'd240, 9'd240};
        rv[6]  = '{1'b1, 4'd10, 9'd1,   9'd1};
        rv[7]  = '{1'b1, 4'd3,  9'd100, 9'd100};
        rv[8]  = '{1'b1, 4'd11, 9'd123, 9'd0};
        rv[9]  = '{1'b0, 4'd15, 9'd0,   9'd0};
        rv[10] = '{1'b1, 4'd7,  9'd271, 9'd271};

        hv[0] = '{0,   1'b0, 1'b0};
        hv[1] = '{8,   1'b0, 1'b0};
        hv[2] = '{9,   1'b1, 1'b0};
        hv[3] = '{264, 1'b1, 1'b0};
        hv[4] = '{265, 1'b0, 1'b0};
        hv[5] = '{304, 1'b0, 1'b0};
        hv[6] = '{305, 1'b0, 1'b1};
        hv[7] = '{336, 1'b0, 1'b1};
        hv[8] = '{337, 1'b0, 1'b0};
        hv[9] = '{383, 1'b0, 1'b0};

        vv[0] = '{0,   1'b1, 1'b0};
        vv[1] = '{255, 1'b1, 1'b0};
        vv[2] = '{256, 1'b0, 1'b0};
        vv[3] = '{263, 1'b0, 1'b0};
        vv[4] = '{264, 1'b0, 1'b1};
        vv[5] = '{269, 1'b0, 1'b1};
        vv[6] = '{270, 1'b0, 1'b0};
        vv[7] = '{283, 1'b0, 1'b0};

        rst = 1'b1; pxl_cen = 1'b0;
        cfg_if.cfg_we = 1'b0; cfg_if.cfg_addr = 4'd0; cfg_if.cfg_din = 9'd0;
        clk1();
        clk1();
        chk("rst_h", 32'(h), 0);
        chk("rst_v", 32'(v), 0);
        chk("rst_vrender", 32'(vrender), 1);
        chk("rst_lhbl", 32'(LHBL), 0);
        chk("rst_lvbl", 32'(LVBL), 1);
        chk("rst_hs", 32'(HS), 0);
        chk("rst_vs", 32'(VS), 0);
        chk("rst_hinit", 32'(hinit), 0);
        chk("rst_vinit", 32'(vinit), 0);
        chk("rst_irq", 32'(line_irq), 0);
        chk("rst_field", 32'(field), 0);
        chk("rst_dout", 32'(cfg_if.cfg_dout), 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            if (rv[i].we) cfg_wr(rv[i].addr, rv[i].din);
            cfg_rd(rv[i].addr, rd);
            chk($sformatf("reg_vec%0d_addr%0d", i, rv[i].addr), 32'(rd), 32'(rv[i].exp));
        end
        do_reset();
        cfg_rd(4'd3, rd);
        chk("rst_discards_hs_end", 32'(rd), 28);
        cfg_rd(4'd9, rd);
        chk("rst_irq_line", 32'(rd), 0);
        cfg_rd(4'd10, rd);
        chk("rst_irq_en", 32'(rd), 0);
        chk("counters_idle_without_cen", 32'(h), 0);

        // Frame 1: HCNT_END written mid-frame, HB_START written on the commit edge.
        gap = 0;
        cfg_wr(4'd9, 9'd240);
        run_frame(31, 100, 4'd4, 9'd39, 1'b1, 4'd1, 9'd17);
        chk("f1_cens", f_cens, 32 * 284);
        chk("f1_maxh", f_maxh, 31);
        chk("f1_hinit", f_hinit, 284);
        chk("f1_irq_disabled", f_irq, 0);
        chk("f1_hb_fall", f_hb_fall, 20);
        chk("f1_lvbl_lines", f_lvbl_low, 28);
        chk("f1_vs_lines", f_vs_hi, 6);
        chk("f1_field", 32'(field), 1);
        chk("f1_end_h", 32'(h), 0);
        chk("f1_end_v", 32'(v), 0);
        chk("f1_end_vrender", 32'(vrender), 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lvbl_v%0d", vv[i].pos), 32'(lvbl_v[vv[i].pos]), 32'(vv[i].lvl_blank));
            chk($sformatf("vs_v%0d", vv[i].pos), 32'(vs_v[vv[i].pos]), 32'(vv[i].lvl_sync));
        end
        cfg_rd(4'd4, rd);
        chk("dout_hcnt_end", 32'(rd), 399 % 512 == 399 ? 39 : 0);
        cfg_rd(4'd1, rd);
        chk("dout_hb_start", 32'(rd), 17);

        // Frame 2: longer lines, line interrupt enabled, VS_START pushed out of range.
        cfg_wr(4'd10, 9'd1);
        run_frame(39, 50, 4'd6, 9'd300, 1'b0, 4'd0, 9'd0);
        chk("f2_cens", f_cens, 40 * 284);
        chk("f2_maxh", f_maxh, 39);
        chk("f2_hb_fall_old", f_hb_fall, 20);
        chk("f2_irq_count", f_irq, 1);
        chk("f2_irq_v", f_irq_v, 240);
        chk("f2_irq_h", f_irq_h, 0);
        chk("f2_vs_lines", f_vs_hi, 6);
        chk("f2_field", 32'(field), 0);

        // Frame 3: HB_START=17 and VS_START=300 active; queue the full-size horizontal timing.
        cfg_wr(4'd0, 9'd9);
        cfg_wr(4'd1, 9'd265);
        cfg_wr(4'd2, 9'd305);
        cfg_wr(4'd3, 9'd337);
        cfg_wr(4'd4, 9'd383);
        run_frame(39, -1, 4'd0, 9'd0, 1'b0, 4'd0, 9'd0);
        chk("f3_cens", f_cens, 40 * 284);
        chk("f3_hb_fall_new", f_hb_fall, 17);
        chk("f3_vs_never", f_vs_hi, 0);
        chk("f3_lvbl_lines", f_lvbl_low, 28);
        chk("f3_hinit", f_hinit, 284);
        chk("f3_irq_count", f_irq, 1);
        chk("f3_field", 32'(field), 1);

        // Frame 4: 384-pixel lines with a pixel enable every 8 clocks.
        gap = 7;
        hs_cnt = 0; lb_cnt = 0; hs_first = -1;
        for (int i = 0; i < 384; i++) begin
            pix();
            lhbl_h[h] = LHBL;
            hs_h[h]   = HS;
            if (HS) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(h);
            end
            if (!LHBL) lb_cnt++;
        end
        chk("line_wrap_h", 32'(h), 0);
        chk("line_wrap_v", 32'(v), 1);
        chk("line_wrap_hinit", 32'(hinit), 1);
        chk("line_wrap_vrender", 32'(vrender), 2);
        chk("hs_width", hs_cnt, 32);
        chk("hs_first", hs_first, 305);
        chk("lhbl_low_count", lb_cnt, 128);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("lhbl_h%0d", hv[i].pos), 32'(lhbl_h[hv[i].pos]), 32'(hv[i].lvl_blank));
            chk($sformatf("hs_h%0d", hv[i].pos), 32'(hs_h[hv[i].pos]), 32'(hv[i].lvl_sync));
        end
        clk1();
        chk("hold_h_between_cens", 32'(h), 0);
        chk("hinit_one_clk", 32'(hinit), 0);

        gap = 0;
        n = 0;
        while (!(v == 9'd100 && h == 9'd200) && n < 50000) begin
            pix();
            n++;
        end
        chk("reached_v100_h200", 32'(v == 9'd100 && h == 9'd200), 1);
        do_reset();
        chk("midrst_h", 32'(h), 0);
        chk("midrst_v", 32'(v), 0);
        chk("midrst_vrender", 32'(vrender), 1);
        chk("midrst_lhbl", 32'(LHBL), 0);
        chk("midrst_lvbl", 32'(LVBL), 1);
        chk("midrst_field", 32'(field), 0);
        cfg_rd(4'd4, rd);
        chk("midrst_hcnt_end", 32'(rd), 31);
        cfg_rd(4'd6, rd);
        chk("midrst_vs_start", 32'(rd), 264);
        for (int i = 0; i < 32; i++) pix();
        chk("midrst_line_len_h", 32'(h), 0);
        chk("midrst_line_len_v", 32'(v), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
